// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the registered sequential ALU.
//   alu_op_t    - 4-bit operation codes (all 16 defined)
//   alu_state_t - sequencer states
//   flags_t     - registered carry/equal flags
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SHL  = 4'h1,
    OP_SHR  = 4'h2,
    OP_MOVA = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_AND  = 4'h6,
    OP_ADDI = 4'h7,
    OP_BNE  = 4'h8,
    OP_BEQ  = 4'h9,
    OP_MOVB = 4'hA,
    OP_MUL  = 4'hB,
    OP_SHLN = 4'hC,
    OP_CMP  = 4'hD,
    OP_SHRN = 4'hE,
    OP_NOP  = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SHIFT = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic carry;
    logic equal;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle datapath.
//   op_i        - operation code
//   a_i, b_i    - operands
//   cin_i       - carry/shift-in
//   result_o    - result value
//   cout_o      - carry out (0 for logic/move ops)
//   eq_o        - a_i == b_i
//   wr_carry_o  - op writes result, carry and clears the high product half
//   wr_equal_o  - op writes the equal flag
// SHLN/SHRN are only resolved here for distances 0 and 1; longer
// distances are sequenced by the top level.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  alu_op_t        op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           cin_i,
  output logic [W-1:0]   result_o,
  output logic           cout_o,
  output logic           eq_o,
  output logic           wr_carry_o,
  output logic           wr_equal_o
);

  localparam int unsigned NW = $clog2(W);
  localparam int unsigned SW = W + 1;

  logic [SW-1:0] sum;
  logic [NW-1:0] n;

  always_comb begin
    result_o   = '0;
    cout_o     = 1'b0;
    wr_carry_o = 1'b0;
    wr_equal_o = 1'b0;
    eq_o       = (a_i == b_i);
    n          = b_i[NW-1:0];
    sum        = {1'b0, a_i} + {1'b0, b_i} + SW'(cin_i);
    case (op_i)
      OP_ADD, OP_ADDI: begin
        {cout_o, result_o} = sum;
        wr_carry_o         = 1'b1;
      end
      OP_SHL: begin
        {cout_o, result_o} = {a_i, cin_i};
        wr_carry_o         = 1'b1;
      end
      OP_SHR: begin
        {result_o, cout_o} = {cin_i, a_i};
        wr_carry_o         = 1'b1;
      end
      OP_MOVA: begin
        result_o   = a_i;
        wr_carry_o = 1'b1;
      end
      OP_OR: begin
        result_o   = a_i | b_i;
        wr_carry_o = 1'b1;
      end
      OP_XOR: begin
        result_o   = a_i ^ b_i;
        wr_carry_o = 1'b1;
      end
      OP_AND: begin
        result_o   = a_i & b_i;
        wr_carry_o = 1'b1;
      end
      OP_MOVB: begin
        result_o   = b_i;
        wr_carry_o = 1'b1;
      end
      // Distance 0 passes A through with carry cleared; otherwise one bit.
      OP_SHLN: begin
        if (n != '0) {cout_o, result_o} = {a_i, 1'b0};
        else         result_o = a_i;
        wr_carry_o = 1'b1;
      end
      OP_SHRN: begin
        if (n != '0) {result_o, cout_o} = {1'b0, a_i};
        else         result_o = a_i;
        wr_carry_o = 1'b1;
      end
      OP_BNE, OP_BEQ, OP_CMP: begin
        wr_equal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake.
//   clk, reset    - clock, synchronous active-high reset
//   start         - request, accepted when busy is 0
//   alu_cmd       - operation code (sampled on accept)
//   inA, inB      - operands (sampled on accept)
//   sc_i          - carry/shift-in (sampled on accept)
//   busy          - multi-cycle MUL/SHLN/SHRN in progress
//   done          - one-cycle pulse when results update
//   rslt, rslt_hi - result / high product half
//   sc_o, equal   - registered carry and compare flags
//   zero, pari    - derived from the rslt register
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         sc_o,
  output logic         zero,
  output logic         pari,
  output logic         equal
);

  localparam int unsigned NW = $clog2(W);
  localparam int unsigned CW = NW + 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = W + 1;

  alu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [W-1:0]  sh_q, sh_d;
  logic          shl_q, shl_d;
  logic [NW-1:0] n_q, n_d;
  logic [W-1:0]  rslt_q, rslt_d;
  logic [W-1:0]  hi_q, hi_d;
  flags_t        flags_q, flags_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  alu_op_t       op_c;
  logic [NW-1:0] n_in;
  logic          accept;
  logic          long_sh;
  logic          mul_last;
  logic          sh_last;
  logic [PW-1:0] prod_nx;
  logic [SW-1:0] sh_nx;

  logic [W-1:0]  core_res;
  logic          core_cout;
  logic          core_eq;
  logic          core_wr_carry;
  logic          core_wr_equal;

  // One shift-add step: conditionally add multiplicand to the high half,
  // then shift the whole {carry, hi, lo} right by one.
  function automatic logic [PW-1:0] mul_step(input logic [PW-1:0] p,
                                             input logic [W-1:0]  m);
    logic [SW-1:0] s;
    s = {1'b0, p[PW-1:W]} + (p[0] ? {1'b0, m} : SW'(0));
    return {s, p[W-1:1]};
  endfunction

  // One zero-fill shift step, returned as {bit shifted out, value}.
  function automatic logic [SW-1:0] sh_step(input logic [W-1:0] v,
                                            input logic         left);
    return left ? {v, 1'b0} : {v[0], 1'b0, v[W-1:1]};
  endfunction

  assign op_c     = alu_op_t'(alu_cmd);
  assign n_in     = inB[NW-1:0];
  assign accept   = start && (state_q == ST_IDLE);
  assign long_sh  = ((op_c == OP_SHLN) || (op_c == OP_SHRN)) && (n_in >= NW'(2));
  assign mul_last = (cnt_q == CW'(W - 1));
  assign sh_last  = (cnt_q == (CW'(n_q) - CW'(1)));
  assign prod_nx  = mul_step(prod_q, mcand_q);
  assign sh_nx    = sh_step(sh_q, shl_q);

  alu_core #(.W(W)) u_core (
    .op_i       (op_c),
    .a_i        (inA),
    .b_i        (inB),
    .cin_i      (sc_i),
    .result_o   (core_res),
    .cout_o     (core_cout),
    .eq_o       (core_eq),
    .wr_carry_o (core_wr_carry),
    .wr_equal_o (core_wr_equal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_c == OP_MUL) state_d = ST_MUL;
          else if (long_sh)   state_d = ST_SHIFT;
        end
      end
      ST_MUL:   if (mul_last) state_d = ST_IDLE;
      ST_SHIFT: if (sh_last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values. The first MUL/SHIFT iteration runs on
  // the accept edge so completion lands on cycle W (MUL) or n (SHIFT).
  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    sh_d    = sh_q;
    shl_d   = shl_q;
    n_d     = n_q;
    rslt_d  = rslt_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_c == OP_MUL) begin
            mcand_d = inA;
            prod_d  = mul_step({{W{1'b0}}, inB}, inA);
            cnt_d   = CW'(1);
          end else if (long_sh) begin
            shl_d = (op_c == OP_SHLN);
            n_d   = n_in;
            sh_d  = (op_c == OP_SHLN) ? {inA[W-2:0], 1'b0} : {1'b0, inA[W-1:1]};
            cnt_d = CW'(1);
          end else begin
            done_d = 1'b1;
            if (core_wr_carry) begin
              rslt_d        = core_res;
              hi_d          = '0;
              flags_d.carry = core_cout;
            end
            if (core_wr_equal) flags_d.equal = core_eq;
          end
        end
      end
      ST_MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q + CW'(1);
        if (mul_last) begin
          done_d        = 1'b1;
          rslt_d        = prod_nx[W-1:0];
          hi_d          = prod_nx[PW-1:W];
          flags_d.carry = |prod_nx[PW-1:W];
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_nx[W-1:0];
        cnt_d = cnt_q + CW'(1);
        if (sh_last) begin
          done_d        = 1'b1;
          rslt_d        = sh_nx[W-1:0];
          hi_d          = '0;
          flags_d.carry = sh_nx[W];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      sh_q    <= '0;
      shl_q   <= 1'b0;
      n_q     <= '0;
      rslt_q  <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      sh_q    <= sh_d;
      shl_q   <= shl_d;
      n_q     <= n_d;
      rslt_q  <= rslt_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rslt    = rslt_q;
  assign rslt_hi = hi_q;
  assign sc_o    = flags_q.carry;
  assign equal   = flags_q.equal;
  assign zero    = (rslt_q == '0);
  assign pari    = ^rslt_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with W = 8.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] alu_cmd;
  logic [7:0] inA, inB;
  logic       sc_i;
  logic       busy, done, sc_o, zero, pari, equal;
  logic [7:0] rslt, rslt_hi;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .alu_cmd (alu_cmd),
    .inA     (inA),
    .inB     (inB),
    .sc_i    (sc_i),
    .busy    (busy),
    .done    (done),
    .rslt    (rslt),
    .rslt_hi (rslt_hi),
    .sc_o    (sc_o),
    .zero    (zero),
    .pari    (pari),
    .equal   (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge, then scramble the operands.
  task automatic issue(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    start = 1'b1; alu_cmd = cmd; inA = a; inB = b; sc_i = c;
    step();
    start = 1'b0; inA = ~a; inB = ~b; sc_i = ~c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (rslt !== 8'h00)    begin failures++; $display("FAIL rst_rslt got=%h exp=00", rslt); end
    checks++; if (rslt_hi !== 8'h00) begin failures++; $display("FAIL rst_hi got=%h exp=00", rslt_hi); end
    checks++; if (sc_o !== 1'b0)     begin failures++; $display("FAIL rst_sc got=%b exp=0", sc_o); end
    checks++; if (equal !== 1'b0)    begin failures++; $display("FAIL rst_equal got=%b exp=0", equal); end
    checks++; if (zero !== 1'b1)     begin failures++; $display("FAIL rst_zero got=%b exp=1", zero); end
    checks++; if (pari !== 1'b0)     begin failures++; $display("FAIL rst_pari got=%b exp=0", pari); end
  endtask

  task automatic test_add();
    issue(4'h0, 8'hF0, 8'h20, 1'b1);
    checks++; if (done !== 1'b1)  begin failures++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL add_busy got=%b exp=0", busy); end
    checks++; if (rslt !== 8'h11) begin failures++; $display("FAIL add_rslt got=%h exp=11", rslt); end
    checks++; if (sc_o !== 1'b1)  begin failures++; $display("FAIL add_sc got=%b exp=1", sc_o); end
    checks++; if (zero !== 1'b0)  begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
    checks++; if (pari !== 1'b0)  begin failures++; $display("FAIL add_pari got=%b exp=0", pari); end
  endtask

  task automatic test_cmp_xor();
    issue(4'hD, 8'h5A, 8'h5A, 1'b0);
    checks++; if (done !== 1'b1)  begin failures++; $display("FAIL cmp_done got=%b exp=1", done); end
    checks++; if (equal !== 1'b1) begin failures++; $display("FAIL cmp_equal got=%b exp=1", equal); end
    checks++; if (rslt !== 8'h11) begin failures++; $display("FAIL cmp_rslt_held got=%h exp=11", rslt); end
    checks++; if (sc_o !== 1'b1)  begin failures++; $display("FAIL cmp_sc_held got=%b exp=1", sc_o); end
    issue(4'h5, 8'h5A, 8'h5A, 1'b1);
    checks++; if (rslt !== 8'h00) begin failures++; $display("FAIL xor_rslt got=%h exp=00", rslt); end
    checks++; if (zero !== 1'b1)  begin failures++; $display("FAIL xor_zero got=%b exp=1", zero); end
    checks++; if (sc_o !== 1'b0)  begin failures++; $display("FAIL xor_sc got=%b exp=0", sc_o); end
    checks++; if (equal !== 1'b1) begin failures++; $display("FAIL xor_equal_held got=%b exp=1", equal); end
    step();
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL xor_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mul();
    issue(4'hB, 8'h0F, 8'h11, 1'b0);
    for (int c = 1; c < 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || rslt !== 8'h00) begin
        failures++;
        $display("FAIL mul_busy_c%0d got busy=%b done=%b rslt=%h exp busy=1 done=0 rslt=00", c, busy, done, rslt);
      end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mul_done got done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (rslt !== 8'hFF)    begin failures++; $display("FAIL mul1_rslt got=%h exp=ff", rslt); end
    checks++; if (rslt_hi !== 8'h00) begin failures++; $display("FAIL mul1_hi got=%h exp=00", rslt_hi); end
    checks++; if (sc_o !== 1'b0)     begin failures++; $display("FAIL mul1_sc got=%b exp=0", sc_o); end
    checks++; if (pari !== 1'b0)     begin failures++; $display("FAIL mul1_pari got=%b exp=0", pari); end
    issue(4'hB, 8'hFF, 8'hFF, 1'b0);
    repeat (7) step();
    checks++; if (done !== 1'b1)     begin failures++; $display("FAIL mul2_done got=%b exp=1", done); end
    checks++; if (rslt !== 8'h01)    begin failures++; $display("FAIL mul2_rslt got=%h exp=01", rslt); end
    checks++; if (rslt_hi !== 8'hFE) begin failures++; $display("FAIL mul2_hi got=%h exp=fe", rslt_hi); end
    checks++; if (sc_o !== 1'b1)     begin failures++; $display("FAIL mul2_sc got=%b exp=1", sc_o); end
  endtask

  task automatic test_shift();
    issue(4'hC, 8'hA1, 8'h03, 1'b0);
    for (int c = 1; c < 3; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || rslt !== 8'h01) begin
        failures++;
        $display("FAIL shln_busy_c%0d got busy=%b done=%b rslt=%h exp 1/0/01", c, busy, done, rslt);
      end
      step();
    end
    checks++; if (done !== 1'b1)     begin failures++; $display("FAIL shln_done got=%b exp=1", done); end
    checks++; if (rslt !== 8'h08)    begin failures++; $display("FAIL shln_rslt got=%h exp=08", rslt); end
    checks++; if (sc_o !== 1'b1)     begin failures++; $display("FAIL shln_sc got=%b exp=1", sc_o); end
    checks++; if (rslt_hi !== 8'h00) begin failures++; $display("FAIL shln_hi got=%h exp=00", rslt_hi); end
    issue(4'hE, 8'h5C, 8'h00, 1'b1);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL shrn0_done got done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (rslt !== 8'h5C || sc_o !== 1'b0) begin failures++; $display("FAIL shrn0 got rslt=%h sc=%b exp 5c/0", rslt, sc_o); end
    issue(4'hE, 8'h03, 8'h01, 1'b0);
    checks++; if (done !== 1'b1 || rslt !== 8'h01 || sc_o !== 1'b1) begin failures++; $display("FAIL shrn1 got done=%b rslt=%h sc=%b exp 1/01/1", done, rslt, sc_o); end
    issue(4'hE, 8'h80, 8'h07, 1'b0);
    repeat (6) step();
    checks++; if (done !== 1'b1 || rslt !== 8'h01 || sc_o !== 1'b0) begin failures++; $display("FAIL shrn7 got done=%b rslt=%h sc=%b exp 1/01/0", done, rslt, sc_o); end
    issue(4'h1, 8'h81, 8'h00, 1'b1);
    checks++; if (rslt !== 8'h03 || sc_o !== 1'b1) begin failures++; $display("FAIL shl got rslt=%h sc=%b exp 03/1", rslt, sc_o); end
    issue(4'h2, 8'h01, 8'h00, 1'b1);
    checks++; if (rslt !== 8'h80 || sc_o !== 1'b1) begin failures++; $display("FAIL shr got rslt=%h sc=%b exp 80/1", rslt, sc_o); end
  endtask

  task automatic test_busy_ignore();
    issue(4'hB, 8'h03, 8'h05, 1'b0);
    repeat (2) step();
    start = 1'b1; alu_cmd = 4'h0; inA = 8'h11; inB = 8'h22; sc_i = 1'b0;
    step();
    start = 1'b0;
    for (int c = 4; c < 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL ign_busy_c%0d got busy=%b done=%b exp 1/0", c, busy, done);
      end
      step();
    end
    checks++; if (done !== 1'b1 || rslt !== 8'h0F || rslt_hi !== 8'h00) begin failures++; $display("FAIL ign_mul got done=%b rslt=%h hi=%h exp 1/0f/00", done, rslt, rslt_hi); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL ign_extra_done got done=%b busy=%b exp 0/0", done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    bit stray;
    issue(4'hB, 8'h0F, 8'h11, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_ctl got busy=%b done=%b exp 0/0", busy, done); end
    checks++; if (rslt !== 8'h00 || rslt_hi !== 8'h00) begin failures++; $display("FAIL rmid_rslt got rslt=%h hi=%h exp 00/00", rslt, rslt_hi); end
    checks++; if (sc_o !== 1'b0 || equal !== 1'b0 || zero !== 1'b1) begin failures++; $display("FAIL rmid_flags got sc=%b eq=%b zero=%b exp 0/0/1", sc_o, equal, zero); end
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rmid_stray got=%b exp=0", stray); end
    issue(4'h0, 8'h01, 8'h01, 1'b0);
    checks++; if (done !== 1'b1 || rslt !== 8'h02) begin failures++; $display("FAIL rmid_add got done=%b rslt=%h exp 1/02", done, rslt); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; alu_cmd = 4'h0; inA = 8'h01; inB = 8'h02; sc_i = 1'b0;
    step();
    checks++; if (done !== 1'b1 || rslt !== 8'h03) begin failures++; $display("FAIL b2b_add got done=%b rslt=%h exp 1/03", done, rslt); end
    alu_cmd = 4'hA; inA = 8'h00; inB = 8'h77;
    step();
    checks++; if (done !== 1'b1 || rslt !== 8'h77 || sc_o !== 1'b0) begin failures++; $display("FAIL b2b_movb got done=%b rslt=%h sc=%b exp 1/77/0", done, rslt, sc_o); end
    alu_cmd = 4'h6; inA = 8'hF0; inB = 8'h3C;
    step();
    checks++; if (done !== 1'b1 || rslt !== 8'h30) begin failures++; $display("FAIL b2b_and got done=%b rslt=%h exp 1/30", done, rslt); end
    alu_cmd = 4'hF; inA = 8'hAA; inB = 8'h55;
    step();
    checks++; if (done !== 1'b1 || rslt !== 8'h30) begin failures++; $display("FAIL b2b_nop got done=%b rslt=%h exp 1/30", done, rslt); end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_cmd = 4'h0; inA = 8'h00; inB = 8'h00; sc_i = 1'b0;
    test_reset();
    test_add();
    test_cmp_xor();
    test_mul();
    test_shift();
    test_busy_ignore();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle ALU. It adds a W-bit datapath, registered result and flags, and a start/done handshake. Multi-cycle operations are multiply (shift-add) and variable-distance shift, executed one bit per cycle. It sits in the execute stage, where the controller stalls on `busy` and latches results on `done`.

## Interface
Parameters:
- `W`, 8: datapath width in bits; must be at least 4 and a power of two.

Ports:
- `clk`: input, 1 bit. Single clock. All state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `start`: input, 1 bit. Request. Accepted only when `busy` is 0.
- `alu_cmd`: input, 4 bits. Operation code, sampled on accept.
- `inA`, `inB`: input, W bits each. Operands, sampled on accept.
- `sc_i`: input, 1 bit. Carry/shift-in, sampled on accept.
- `busy`: output, 1 bit. A multi-cycle operation is in progress.
- `done`: output, 1 bit. One-cycle pulse; result and flags are updated this cycle.
- `rslt`: output, W bits. Registered result, low half for MUL.
- `rslt_hi`: output, W bits. High half of the MUL product; 0 after every other operation that writes `rslt`.
- `sc_o`: output, 1 bit. Registered carry flag.
- `zero`: output, 1 bit. Combinational from the `rslt` register: `rslt == 0`.
- `pari`: output, 1 bit. Combinational from the `rslt` register: `^rslt`.
- `equal`: output, 1 bit. Registered compare flag.

## Operation
Operation codes:
- 0000 ADD: {carry, rslt} = A + B + sc_i.
- 0001 SHL: {carry, rslt} = {A, sc_i}.
- 0010 SHR: {rslt, carry} = {sc_i, A}.
- 0011 MOVA: rslt = A.
- 0100 OR, 0101 XOR, 0110 AND: bitwise on A and B.
- 0111 ADDI: same as ADD.
- 1010 MOVB: rslt = B.
- 1000 BNE, 1001 BEQ, 1101 CMP: equal = (A == B).
- 1011 MUL: unsigned {rslt_hi, rslt} = A × B, W iterations. carry = |product high half.
- 1100 SHLN, 1110 SHRN: shift A by n = B[log2 W − 1 : 0], zero fill. carry = last bit shifted out. If n = 0, rslt = A and carry = 0.
- 1111 NOP: no state change except `done`.

Flag update rules:
- ADD, ADDI, SHL, SHR, SHLN, SHRN and MUL write `sc_o`.
- OR, XOR, AND, MOVA and MOVB write `rslt`, clear `sc_o` and clear `rslt_hi`.
- BNE, BEQ and CMP write only `equal`; `rslt`, `rslt_hi` and `sc_o` are held.
- `equal` is held by every operation that is not a compare.

Arithmetic and width:
- All arithmetic is modulo 2^W, except that MUL keeps the full 2W-bit product.
- The adder is W+1 bits wide.

State machine (states IDLE, MUL, SHIFT):
- IDLE: on `start` with a single-cycle code, the result is registered at the next edge and the block stays in IDLE. With MUL it goes to MUL. With SHLN/SHRN and n ≥ 2 it goes to SHIFT; with n ∈ {0,1} it completes in one cycle, like a single-cycle op.
- MUL: one partial-product add and shift per cycle, counting iterations 0..W−1. After the last iteration it returns to IDLE.
- SHIFT: one bit per cycle, n iterations in total, then returns to IDLE.

Operand handling:
- Operands are latched internally on accept. Input changes after accept have no effect.
- Partial results are not visible on `rslt` until `done`.

Boundary cases:
- `start` while `busy` is 1 is ignored; nothing is queued.
- `start` in the same cycle that `done` is 1 is accepted, because `busy` is already 0. Back-to-back single-cycle ops give `done` every cycle.
- `reset` at any time, including mid-MUL or mid-SHIFT, aborts the operation and returns to IDLE. No `done` is issued for the aborted op.
- An undefined code (none in the 4-bit set) behaves as NOP.

## Timing
Reset values:
- State is IDLE.
- `busy`, `done`, `rslt`, `rslt_hi`, `sc_o` and `equal` are 0.
- Consequently `zero` = 1 and `pari` = 0.

Latency (accept edge = cycle 0):
- Single-cycle ops: `done` = 1 in cycle 1.
- MUL: `busy` = 1 in cycles 1..W−1, `done` = 1 in cycle W.
- SHLN/SHRN with n ≥ 2: `busy` = 1 in cycles 1..n−1, `done` = 1 in cycle n.

Output timing:
- `busy` and `done` are never both 1 in the same cycle.
- `done` is registered. `zero` and `pari` are valid in the same cycle as `done`.

## Structure
- Package `alu_pkg` holds: the `alu_op_t` enum with all 16 codes, the `alu_state_t` enum {IDLE, MUL, SHIFT}, and a `flags_t` struct {carry, equal}.
- Sub-module `alu_core` holds the combinational single-cycle datapath (parametrised on W). Its inputs are op, A, B and cin; its outputs are result, cout, eq and writes-carry/writes-equal enables.
- The top level owns the FSM, the iteration counter ($clog2(W)+1 bits), the operand/product shift registers, and the output registers.

## Test plan
All scenarios use W = 8.
1. ADD: A = 0xF0, B = 0x20, sc_i = 1 → cycle 1: `done` = 1, `rslt` = 0x11, `sc_o` = 1, `zero` = 0, `pari` = 0.
2. MUL: A = 0x0F, B = 0x11 → `busy` in cycles 1–7, `done` in cycle 8, `rslt` = 0xFF, `rslt_hi` = 0x00, `sc_o` = 0, `pari` = 0. Then MUL 0xFF × 0xFF → `rslt` = 0x01, `rslt_hi` = 0xFE, `sc_o` = 1.
3. SHLN: A = 0xA1, B = 0x03 → `done` in cycle 3, `rslt` = 0x08, `sc_o` = 1. SHRN with B = 0x00 → `done` in cycle 1, `rslt` = A, `sc_o` = 0.
4. CMP: A = B = 0x5A right after scenario 1 → `equal` = 1; `rslt` stays 0x11 and `sc_o` stays 1. Then XOR 0x5A, 0x5A → `rslt` = 0, `zero` = 1, `sc_o` = 0, `equal` still 1.
5. `start` with ADD during MUL cycle 3 → ignored. MUL completes with the correct product; no extra `done`.
6. `reset` in MUL cycle 4 → next cycle: IDLE, all outputs at reset values, no `done`. A following ADD 0x01 + 0x01 → `rslt` = 0x02 in cycle 1.
